// File: rtl/gpio_in_filter.sv
// gpio_in_filter: input conditioning for the gpio register block.
// Each pad input is synchronised through two flops and then debounced by a
// per-pin stability counter. The filtered level, single-cycle rise/fall pulses,
// sticky edge-pending flags and a combined interrupt are all registered.
module gpio_in_filter #(
  parameter int NUM_PINS      = 2,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] pin_i,
  input  logic [NUM_PINS-1:0] en_i,
  input  logic [NUM_PINS-1:0] clr_i,
  output logic [NUM_PINS-1:0] pin_o,
  output logic [NUM_PINS-1:0] rise_o,
  output logic [NUM_PINS-1:0] fall_o,
  output logic [NUM_PINS-1:0] pending_o,
  output logic                irq_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  // Terminal count: when reached with the input still differing, the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser stages
  logic [NUM_PINS-1:0] s1_r;
  logic [NUM_PINS-1:0] s2_r;

  // Filter state and registered outputs
  logic [CNT_W-1:0]    cnt_r [NUM_PINS];
  logic [NUM_PINS-1:0] pin_r;
  logic [NUM_PINS-1:0] rise_r;
  logic [NUM_PINS-1:0] fall_r;
  logic [NUM_PINS-1:0] pending_r;
  logic                irq_r;

  // Next-state values
  logic [CNT_W-1:0]    cnt_s [NUM_PINS];
  logic [NUM_PINS-1:0] pin_s;
  logic [NUM_PINS-1:0] rise_s;
  logic [NUM_PINS-1:0] fall_s;
  logic [NUM_PINS-1:0] pending_s;

  // Per-pin debounce decision: count while the synchronised level differs, accept at terminal count
  always_comb begin
    pin_s  = pin_r;
    rise_s = {NUM_PINS{1'b0}};
    fall_s = {NUM_PINS{1'b0}};
    for (int n = 0; n < NUM_PINS; n++) begin
      cnt_s[n] = cnt_r[n];
      if (!en_i[n]) begin
        cnt_s[n] = CNT_ZERO;
      end else if (s2_r[n] == pin_r[n]) begin
        // Input agrees with the filtered level (or a glitch returned): restart qualification
        cnt_s[n] = CNT_ZERO;
      end else if (cnt_r[n] == CNT_LAST) begin
        cnt_s[n]  = CNT_ZERO;
        pin_s[n]  = s2_r[n];
        rise_s[n] = s2_r[n];
        fall_s[n] = ~s2_r[n];
      end else begin
        cnt_s[n] = cnt_r[n] + CNT_ONE;
      end
    end
    // A new edge in the same cycle as a clear keeps the flag set
    pending_s = (pending_r & ~clr_i) | rise_s | fall_s;
  end

  // State registers: synchroniser always runs; everything clears on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r      <= {NUM_PINS{1'b0}};
      s2_r      <= {NUM_PINS{1'b0}};
      pin_r     <= {NUM_PINS{1'b0}};
      rise_r    <= {NUM_PINS{1'b0}};
      fall_r    <= {NUM_PINS{1'b0}};
      pending_r <= {NUM_PINS{1'b0}};
      irq_r     <= 1'b0;
      for (int n = 0; n < NUM_PINS; n++) begin
        cnt_r[n] <= CNT_ZERO;
      end
    end else begin
      s1_r      <= pin_i;
      s2_r      <= s1_r;
      pin_r     <= pin_s;
      rise_r    <= rise_s;
      fall_r    <= fall_s;
      pending_r <= pending_s;
      irq_r     <= |pending_s;
      for (int n = 0; n < NUM_PINS; n++) begin
        cnt_r[n] <= cnt_s[n];
      end
    end
  end

  assign pin_o     = pin_r;
  assign rise_o    = rise_r;
  assign fall_o    = fall_r;
  assign pending_o = pending_r;
  assign irq_o     = irq_r;

endmodule
